// File: rtl/router_1x3.sv
`default_nettype none
// ============================================================================
//  Module   : router_1x3 (with helper router_fifo)
//  Purpose  : 1-input, 3-output byte-serial packet router with parity check,
//             per-port 16-deep FIFOs and idle-timeout soft reset.
//  Revision : 1.0  initial release
// ============================================================================

module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH:0]   din,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [WIDTH-2:0] CNT_ONE = (WIDTH-1)'(1);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-2:0] count_q, count_d;
  logic [WIDTH:0]   rd_word;
  logic             do_wr, do_rd;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr    = we & ~full;
  assign do_rd    = re & ~empty;
  assign rd_word  = mem_q[rd_ptr_q[AW-1:0]];
  assign data_out = data_out_q;

  // count_q holds the bytes still owed for the packet being read (payload + parity)
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    count_d    = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = rd_word[WIDTH-1:0];
      if (rd_word[WIDTH])      count_d = {1'b0, rd_word[WIDTH-1:2]} + CNT_ONE;
      else if (count_q != '0)  count_d = count_q - CNT_ONE;
    end else if (count_q == '0) begin
      data_out_d = '0;
    end
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      data_out_d = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

module router_1x3 #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb_0,
  input  logic             read_enb_1,
  input  logic             read_enb_2,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic [WIDTH-1:0] data_out_2,
  output logic             vld_out_0,
  output logic             vld_out_1,
  output logic             vld_out_2,
  output logic             busy,
  output logic             err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic [2:0] {
    DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA,
    FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hdr_q, hdr_d, parity_calc_q, parity_calc_d;
  logic [WIDTH-1:0] parity_rx_q, parity_rx_d, hold_q, hold_d;
  logic [1:0]       dest_q, dest_d;
  logic             hold_par_q, hold_par_d, err_q, err_d, skip_q, skip_d;
  logic [2:0]       soft_reset_q, soft_reset_d;
  logic [TW-1:0]    timer_q [3];
  logic [TW-1:0]    timer_d [3];

  logic [2:0]       fifo_full, fifo_empty, fifo_we, rd_en, vld;
  logic [3:0]       full_v, empty_v, sr_v;
  logic [WIDTH:0]   fifo_din;
  logic             wr_en, writing, abort, data_phase;

  assign rd_en   = {read_enb_2, read_enb_1, read_enb_0};
  assign vld     = ~fifo_empty;
  assign full_v  = {1'b1, fifo_full};
  assign empty_v = {1'b0, fifo_empty};
  assign sr_v    = {1'b0, soft_reset_q};
  assign {vld_out_2, vld_out_1, vld_out_0} = vld;

  assign busy = ~(state_q == DECODE_ADDRESS || state_q == LOAD_DATA);
  assign err  = err_q;

  assign writing = state_q inside {LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
                                   LOAD_AFTER_FULL, LOAD_PARITY};
  assign abort   = writing & sr_v[dest_q];
  // Source is mid-packet when aborted: its remaining bytes must not be taken as a header
  assign data_phase = (state_q == LOAD_FIRST_DATA) ||
                      (state_q == LOAD_DATA && pkt_valid) ||
                      ((state_q == FIFO_FULL_STATE || state_q == LOAD_AFTER_FULL) && !hold_par_q);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      timer_d[i]      = '0;
      soft_reset_d[i] = 1'b0;
      if (vld[i] && !rd_en[i] && !soft_reset_q[i]) begin
        if (timer_q[i] == TMO_LAST) soft_reset_d[i] = 1'b1;
        else                        timer_d[i]      = timer_q[i] + TMR_ONE;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    dest_d        = dest_q;
    parity_calc_d = parity_calc_q;
    parity_rx_d   = parity_rx_q;
    hold_d        = hold_q;
    hold_par_d    = hold_par_q;
    err_d         = err_q;
    skip_d        = skip_q;
    wr_en         = 1'b0;
    fifo_din      = {1'b0, data_in};
    case (state_q)
      DECODE_ADDRESS: begin
        if (skip_q) begin
          if (!pkt_valid) skip_d = 1'b0;
        end else if (pkt_valid) begin
          if (data_in[1:0] == 2'd3) begin
            skip_d = 1'b1;
          end else begin
            hdr_d         = data_in;
            dest_d        = data_in[1:0];
            err_d         = 1'b0;
            parity_calc_d = data_in;
            state_d       = empty_v[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      WAIT_TILL_EMPTY: if (empty_v[dest_q]) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA: begin
        wr_en    = 1'b1;
        fifo_din = {1'b1, hdr_q};
        state_d  = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (pkt_valid) begin
          parity_calc_d = parity_calc_q ^ data_in;
          if (!full_v[dest_q]) begin
            wr_en = 1'b1;
          end else begin
            hold_d     = data_in;
            hold_par_d = 1'b0;
            state_d    = FIFO_FULL_STATE;
          end
        end else begin
          parity_rx_d = data_in;
          state_d     = LOAD_PARITY;
        end
      end
      LOAD_PARITY: begin
        if (!full_v[dest_q]) begin
          wr_en    = 1'b1;
          fifo_din = {1'b0, parity_rx_q};
          state_d  = CHECK_PARITY_ERROR;
        end else begin
          hold_d     = parity_rx_q;
          hold_par_d = 1'b1;
          state_d    = FIFO_FULL_STATE;
        end
      end
      FIFO_FULL_STATE: if (!full_v[dest_q]) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        wr_en    = ~full_v[dest_q];
        fifo_din = {1'b0, hold_q};
        state_d  = hold_par_q ? CHECK_PARITY_ERROR : LOAD_DATA;
      end
      CHECK_PARITY_ERROR: begin
        err_d         = (parity_calc_q != parity_rx_q);
        parity_calc_d = '0;
        state_d       = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    if (abort) begin
      wr_en         = 1'b0;
      parity_calc_d = '0;
      skip_d        = data_phase;
      state_d       = DECODE_ADDRESS;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) fifo_we[i] = wr_en && (dest_q == 2'(i));
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q       <= DECODE_ADDRESS;
      hdr_q         <= '0;
      dest_q        <= '0;
      parity_calc_q <= '0;
      parity_rx_q   <= '0;
      hold_q        <= '0;
      hold_par_q    <= 1'b0;
      err_q         <= 1'b0;
      skip_q        <= 1'b0;
      soft_reset_q  <= '0;
      for (int i = 0; i < 3; i++) timer_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      dest_q        <= dest_d;
      parity_calc_q <= parity_calc_d;
      parity_rx_q   <= parity_rx_d;
      hold_q        <= hold_d;
      hold_par_q    <= hold_par_d;
      err_q         <= err_d;
      skip_q        <= skip_d;
      soft_reset_q  <= soft_reset_d;
      for (int i = 0; i < 3; i++) timer_q[i] <= timer_d[i];
    end
  end

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO_0 (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset_q[0]), .we(fifo_we[0]),
    .re(read_enb_0), .din(fifo_din), .data_out(data_out_0),
    .full(fifo_full[0]), .empty(fifo_empty[0])
  );

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO_1 (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset_q[1]), .we(fifo_we[1]),
    .re(read_enb_1), .din(fifo_din), .data_out(data_out_1),
    .full(fifo_full[1]), .empty(fifo_empty[1])
  );

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO_2 (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset_q[2]), .we(fifo_we[2]),
    .re(read_enb_2), .din(fifo_din), .data_out(data_out_2),
    .full(fifo_full[2]), .empty(fifo_empty[2])
  );
endmodule

`default_nettype wire

// File: tb/tb_router_1x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_1x3
//  Purpose  : Scoreboard bench for router_1x3 packet routing, parity, timeout.
//  Revision : 1.0  initial release
// ============================================================================
module tb_router_1x3;
  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic [2:0] rd_en = '0;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       vld_out_0, vld_out_1, vld_out_2, busy, err;

  int vectors = 0;
  int miscompares = 0;
  int busy_cycles = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  router_1x3 dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb_0(rd_en[0]), .read_enb_1(rd_en[1]), .read_enb_2(rd_en[2]),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic vld_of(input int p);
    case (p)
      0: return vld_out_0;
      1: return vld_out_1;
      default: return vld_out_2;
    endcase
  endfunction

  task automatic sb_push(input logic [1:0] p, input logic [7:0] b);
    case (p)
      2'd0: q0.push_back(b);
      2'd1: q1.push_back(b);
      2'd2: q2.push_back(b);
      default: ;
    endcase
  endtask

  task automatic pop_check(input int p, input logic [7:0] got);
    logic [7:0] exp_b;
    check($sformatf("q%0d_has_entry", p), 32'(qsize(p) != 0), 32'(1));
    if (qsize(p) != 0) begin
      case (p)
        0: exp_b = q0.pop_front();
        1: exp_b = q1.pop_front();
        default: exp_b = q2.pop_front();
      endcase
      check($sformatf("data_out_%0d", p), 32'(got), 32'(exp_b));
    end
  endtask

  // pops are decided on the settled pre-edge values and compared just after the edge
  initial begin : monitor
    logic [2:0] pend;
    forever begin
      @(negedge clock); #1;
      pend = rd_en & {vld_out_2, vld_out_1, vld_out_0};
      @(posedge clock); #1;
      if (pend[0]) pop_check(0, data_out_0);
      if (pend[1]) pop_check(1, data_out_1);
      if (pend[2]) pop_check(2, data_out_2);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic v, input logic [1:0] dst);
    int n = 0;
    data_in   = b;
    pkt_valid = v;
    while (busy === 1'b1 && n < 100) begin
      busy_cycles++;
      n++;
      @(negedge clock);
    end
    if (n >= 100) check("busy_bound", 32'(n), 32'(0));
    @(negedge clock);
    if (dst != 2'd3) sb_push(dst, b);
  endtask

  task automatic send_packet(input logic [1:0] addr, input int len, input logic corrupt);
    logic [7:0] hdr, par, b;
    int n = 0;
    busy_cycles = 0;
    hdr = {6'(len), addr};
    par = hdr;
    send_byte(hdr, 1'b1, addr);
    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom_range(0, 255));
      par = par ^ b;
      send_byte(b, 1'b1, addr);
    end
    send_byte(corrupt ? (par ^ 8'h01) : par, 1'b0, addr);
    pkt_valid = 1'b0;
    data_in   = '0;
    while (busy === 1'b1 && n < 100) begin
      busy_cycles++;
      n++;
      @(negedge clock);
    end
    if (n >= 100) check("tail_bound", 32'(n), 32'(0));
  endtask

  task automatic drain(input int p);
    int n = 0;
    rd_en[p] = 1'b1;
    while ((vld_of(p) || qsize(p) != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check($sformatf("drain%0d_bound", p), 32'(n), 32'(0));
    rd_en[p] = 1'b0;
    check($sformatf("q%0d_drained", p), 32'(qsize(p)), 32'(0));
  endtask

  initial begin : stimulus
    int n, c;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'(0));
    check("rst_dout0", 32'(data_out_0), 32'(0));
    check("rst_dout1", 32'(data_out_1), 32'(0));
    check("rst_dout2", 32'(data_out_2), 32'(0));

    // L=5 to port 2, good parity
    send_packet(2'd2, 5, 1'b0);
    check("t1_err", 32'(err), 32'(0));
    check("t1_vld2", 32'(vld_out_2), 32'(1));
    drain(2);
    check("t1_vld2_low", 32'(vld_out_2), 32'(0));
    repeat (2) @(negedge clock);
    check("t1_dout2_zero", 32'(data_out_2), 32'(0));

    // L=14 to port 1 fills FIFO exactly, busy only in the three fixed states
    send_packet(2'd1, 14, 1'b0);
    check("t2_busy_cycles", 32'(busy_cycles), 32'(3));
    check("t2_err", 32'(err), 32'(0));
    drain(1);

    // L=16 to port 0 overflows FIFO, reader starts only once the router stalls
    fork
      send_packet(2'd0, 16, 1'b0);
      begin
        n = 0;
        c = 0;
        while (c < 3 && n < 100) begin
          @(negedge clock);
          n++;
          c = (busy === 1'b1) ? c + 1 : 0;
        end
        check("t3_busy_full", 32'(busy), 32'(1));
        check("t3_full", 32'(dut.fifo_full[0]), 32'(1));
        drain(0);
      end
    join
    check("t3_q0_empty", 32'(q0.size()), 32'(0));
    check("t3_err", 32'(err), 32'(0));

    // corrupted parity on port 2
    send_packet(2'd2, 5, 1'b1);
    check("t4_err_set", 32'(err), 32'(1));
    drain(2);
    check("t4_err_hold", 32'(err), 32'(1));

    // L=3 to port 1 never read: timeout flush
    send_packet(2'd1, 3, 1'b0);
    check("t5_err_cleared", 32'(err), 32'(0));
    repeat (15) @(negedge clock);
    check("t5_vld1_before_timeout", 32'(vld_out_1), 32'(1));
    n = 0;
    while (vld_out_1 === 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("t5_vld1_flushed", 32'(vld_out_1), 32'(0));
    check("t5_fifo1_empty", 32'(dut.FIFO_1.empty), 32'(1));
    q1.delete();

    // addr 3 packet is dropped, next packet routes normally
    send_packet(2'd3, 2, 1'b0);
    check("t6_busy_cycles", 32'(busy_cycles), 32'(0));
    check("t6_no_write", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'(0));
    send_packet(2'd0, 2, 1'b0);
    check("t6_vld0", 32'(vld_out_0), 32'(1));
    drain(0);
    check("t6_err", 32'(err), 32'(0));

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
